// File: rtl/video_pkg.sv
// Shared definitions for the FIFO pixel unpacker.
//   - unpacker_state_e : controller state (idle until the first frame_start)
//   - num_slots        : packed pixels per FIFO word
//   - slot_index       : maps the sequential slot counter onto a slot position
//   - line_cnt_width   : width needed to count 0..v_disp lines
//   - DefaultFillPixel : pixel substituted when the FIFO runs dry
package video_pkg;

   typedef enum logic {StIdle, StActive} unpacker_state_e;

   localparam logic [23:0] DefaultFillPixel = 24'h000000;

   function automatic int unsigned num_slots(input int unsigned data_width,
                                             input int unsigned slot_bits);
      return data_width / slot_bits;
   endfunction

   // With msb_first, sequential slot 0 lives in the topmost container of the word.
   function automatic int unsigned slot_index(input int unsigned cnt,
                                              input int unsigned n,
                                              input bit          msb_first);
      return msb_first ? (n - 1 - cnt) : cnt;
   endfunction

   function automatic int unsigned line_cnt_width(input int unsigned v_disp);
      return $clog2(v_disp + 1);
   endfunction

endpackage

// File: rtl/burst_credit_ctr.sv
// Saturating burst-credit counter with a registered valid/ready request.
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_load         : frame restart, discards pending credits and loads one
//   i_inc          : request one more burst (next-line prefetch)
//   i_ready        : burst accepted by the AXI read master
//   o_valid        : registered, high while credits are outstanding
//   o_ovf          : an increment was dropped because the counter is full
module burst_credit_ctr #(
   parameter int unsigned CNT_W = 3
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_load,
   input  logic i_inc,
   input  logic i_ready,
   output logic o_valid,
   output logic o_ovf
);

   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_next;
   logic             r_valid;
   logic             w_xfer;

   assign w_xfer  = r_valid && i_ready;
   assign o_valid = r_valid;

   always_comb begin
      w_cnt_next = r_cnt;
      o_ovf      = 1'b0;
      if (i_load) begin
         w_cnt_next = CNT_W'(1);
      end else if (i_inc && !w_xfer) begin
         if (r_cnt == CntMax) begin
            o_ovf = 1'b1;
         end else begin
            w_cnt_next = r_cnt + 1'b1;
         end
      end else if (!i_inc && w_xfer) begin
         // r_valid implies r_cnt != 0, so this never wraps.
         w_cnt_next = r_cnt - 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_cnt   <= '0;
         r_valid <= 1'b0;
      end else begin
         r_cnt   <= w_cnt_next;
         r_valid <= (w_cnt_next != '0);
      end
   end

endmodule

// File: rtl/fifo_pixel_unpacker.sv
// Unpacks wide show-ahead FIFO words into one pixel per data_req, issues
// per-line burst requests and flushes the FIFO at each frame start.
// Ports:
//   video_clk, video_rst_n : pixel clock, synchronous active-low reset
//   frame_start, line_start: vsync / DE rising-edge pulses
//   data_req               : pixel request from the timing generator
//   fifo_data_in, fifo_empty, fifo_rd_en, fifo_rst_n : read FIFO interface
//   pixel_data             : registered pixel, one cycle after data_req
//   burst_valid/ready      : burst request handshake to the AXI read master
//   line_cnt               : active lines started in this frame
//   underflow              : sticky FIFO-underflow / credit-overflow flag
module fifo_pixel_unpacker
   import video_pkg::*;
#(
   parameter int unsigned          DATA_WIDTH = 128,
   parameter int unsigned          SLOT_BITS  = 32,
   parameter int unsigned          PIX_BITS   = 24,
   parameter int unsigned          MSB_FIRST  = 1,
   parameter int unsigned          V_DISP     = 1080,
   parameter logic [PIX_BITS-1:0]  FILL_PIXEL = PIX_BITS'(DefaultFillPixel),
   parameter int unsigned          REQ_CNT_W  = 3
) (
   input  logic                                   video_clk,
   input  logic                                   video_rst_n,
   input  logic                                   frame_start,
   input  logic                                   line_start,
   input  logic                                   data_req,
   input  logic [DATA_WIDTH-1:0]                  fifo_data_in,
   input  logic                                   fifo_empty,
   output logic                                   fifo_rd_en,
   output logic                                   fifo_rst_n,
   output logic [PIX_BITS-1:0]                    pixel_data,
   output logic                                   burst_valid,
   input  logic                                   burst_ready,
   output logic [line_cnt_width(V_DISP)-1:0]      line_cnt,
   output logic                                   underflow
);

   localparam int unsigned      N  = num_slots(DATA_WIDTH, SLOT_BITS);
   localparam int unsigned      SW = (N < 2) ? 1 : $clog2(N);
   localparam int unsigned      LW = line_cnt_width(V_DISP);
   localparam logic [SW-1:0]    SlotLast       = SW'(N - 1);
   localparam logic [LW-1:0]    LineMax        = LW'(V_DISP);
   localparam logic [LW-1:0]    LinePrefetchLim = LW'(V_DISP - 1);

   if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_slots
      $error("DATA_WIDTH/SLOT_BITS must be a power of two >= 2");
   end
   if (DATA_WIDTH % SLOT_BITS != 0) begin : g_bad_width
      $error("DATA_WIDTH must be a multiple of SLOT_BITS");
   end
   if (PIX_BITS > SLOT_BITS) begin : g_bad_pix
      $error("PIX_BITS must not exceed SLOT_BITS");
   end

   unpacker_state_e r_state, w_state_next;

   logic [SW-1:0]              r_slot_cnt, w_slot_cnt_next;
   logic [PIX_BITS-1:0]        r_pixel, w_pixel_next;
   logic [LW-1:0]              r_line_cnt, w_line_cnt_next;
   logic                       r_underflow, w_underflow_next;
   logic                       r_flush;
   logic                       w_active;
   logic                       w_take;
   logic                       w_credit_inc;
   logic                       w_credit_ovf;
   logic [N-1:0][SLOT_BITS-1:0] w_slots;
   logic [SW-1:0]              w_sel;
   logic [PIX_BITS-1:0]        w_slot_pix;

   assign w_slots    = fifo_data_in;
   assign w_sel      = SW'(slot_index(32'(r_slot_cnt), N, MSB_FIRST != 0));
   assign w_slot_pix = w_slots[w_sel][PIX_BITS-1:0];

   assign w_active = (r_state == StActive);
   assign w_take   = w_active && data_req && !fifo_empty;
   // Pop in the same cycle the last slot of the word is consumed.
   assign fifo_rd_en = w_take && (r_slot_cnt == SlotLast) && !r_flush;

   // Prefetch the next line's burst unless this is the last active line.
   assign w_credit_inc = w_active && line_start && !frame_start &&
                         (r_line_cnt < LinePrefetchLim);

   assign fifo_rst_n = !r_flush;
   assign pixel_data = r_pixel;
   assign line_cnt   = r_line_cnt;
   assign underflow  = r_underflow;

   burst_credit_ctr #(
      .CNT_W (REQ_CNT_W)
   ) u_credit (
      .i_clk   (video_clk),
      .i_rst_n (video_rst_n),
      .i_load  (frame_start),
      .i_inc   (w_credit_inc),
      .i_ready (burst_ready),
      .o_valid (burst_valid),
      .o_ovf   (w_credit_ovf)
   );

   always_comb begin
      w_state_next = r_state;
      if (frame_start) begin
         w_state_next = StActive;
      end
   end

   always_ff @(posedge video_clk) begin
      if (!video_rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_pixel_next     = r_pixel;
      w_slot_cnt_next  = r_slot_cnt;
      w_line_cnt_next  = r_line_cnt;
      w_underflow_next = r_underflow;

      if (w_active && data_req) begin
         if (!fifo_empty) begin
            w_pixel_next    = w_slot_pix;
            w_slot_cnt_next = r_slot_cnt + 1'b1;
         end else begin
            // Conceal the gap and hold position so the word resumes intact.
            w_pixel_next     = FILL_PIXEL;
            w_underflow_next = 1'b1;
         end
      end

      if (w_active && line_start && (r_line_cnt != LineMax)) begin
         w_line_cnt_next = r_line_cnt + 1'b1;
      end

      if (w_credit_ovf) begin
         w_underflow_next = 1'b1;
      end

      // Frame restart overrides everything; the pixel above still used the old slot.
      if (frame_start) begin
         w_slot_cnt_next  = '0;
         w_line_cnt_next  = '0;
         w_underflow_next = 1'b0;
      end
   end

   always_ff @(posedge video_clk) begin
      if (!video_rst_n) begin
         r_pixel     <= '0;
         r_slot_cnt  <= '0;
         r_line_cnt  <= '0;
         r_underflow <= 1'b0;
         r_flush     <= 1'b0;
      end else begin
         r_pixel     <= w_pixel_next;
         r_slot_cnt  <= w_slot_cnt_next;
         r_line_cnt  <= w_line_cnt_next;
         r_underflow <= w_underflow_next;
         r_flush     <= frame_start;
      end
   end

endmodule

// File: tb/tb_fifo_pixel_unpacker.sv
module tb_fifo_pixel_unpacker;

   localparam logic [23:0] Fill = 24'hDEAD01;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          frame_start, line_start, data_req;
   logic [127:0]  fifo_data_in;
   logic          fifo_empty;
   logic          fifo_rd_en, fifo_rst_n;
   logic [23:0]   pixel_data;
   logic          burst_valid, burst_ready;
   logic [2:0]    line_cnt;
   logic          underflow;

   int tests = 0;
   int fails = 0;
   int xfers = 0;
   int rd_pulses = 0;
   int base;
   logic [23:0] sb[$];

   always #5 clk = ~clk;

   fifo_pixel_unpacker #(
      .DATA_WIDTH (128),
      .SLOT_BITS  (32),
      .PIX_BITS   (24),
      .MSB_FIRST  (1),
      .V_DISP     (4),
      .FILL_PIXEL (Fill),
      .REQ_CNT_W  (3)
   ) dut (
      .video_clk    (clk),
      .video_rst_n  (rst_n),
      .frame_start  (frame_start),
      .line_start   (line_start),
      .data_req     (data_req),
      .fifo_data_in (fifo_data_in),
      .fifo_empty   (fifo_empty),
      .fifo_rd_en   (fifo_rd_en),
      .fifo_rst_n   (fifo_rst_n),
      .pixel_data   (pixel_data),
      .burst_valid  (burst_valid),
      .burst_ready  (burst_ready),
      .line_cnt     (line_cnt),
      .underflow    (underflow)
   );

   always @(posedge clk) begin
      if (burst_valid && burst_ready) xfers++;
      if (fifo_rd_en) rd_pulses++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; compare any pixel the scoreboard expects from it.
   task automatic cycle();
      logic [23:0] e;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("pixel", 32'(pixel_data), 32'(e));
      end
   endtask

   // Issue one data_req (left asserted for back-to-back requests).
   task automatic req(input logic [23:0] exp_pix, input logic exp_rd);
      data_req = 1'b1;
      sb.push_back(exp_pix);
      #1;
      check("rd_en", 32'(fifo_rd_en), 32'(exp_rd));
      cycle();
   endtask

   localparam logic [127:0] W0 = 128'h00AABBCC_00112233_00445566_00778899;
   localparam logic [127:0] W1 = 128'h00111111_00222222_00333333_00444444;
   localparam logic [127:0] W2 = 128'h00555555_00666666_00777777_00888888;

   initial begin
      rst_n = 1'b0; frame_start = 0; line_start = 0; data_req = 0;
      fifo_data_in = W0; fifo_empty = 1'b0; burst_ready = 1'b0;
      cycle(); cycle();
      check("rst_pixel", 32'(pixel_data), 0);
      check("rst_fifo_rst_n", 32'(fifo_rst_n), 1);
      check("rst_valid", 32'(burst_valid), 0);
      check("rst_underflow", 32'(underflow), 0);
      check("rst_line_cnt", 32'(line_cnt), 0);
      rst_n = 1'b1;
      data_req = 1'b1;
      #1 check("idle_rd_en", 32'(fifo_rd_en), 0);
      cycle();
      check("idle_pixel", 32'(pixel_data), 0);
      data_req = 1'b0;

      // Frame start: one flush cycle and one line-0 burst.
      burst_ready = 1'b1; frame_start = 1'b1;
      cycle();
      frame_start = 1'b0;
      check("flush_low", 32'(fifo_rst_n), 0);
      check("fs_valid", 32'(burst_valid), 1);
      cycle();
      check("flush_end", 32'(fifo_rst_n), 1);
      check("fs_valid_drop", 32'(burst_valid), 0);
      check("fs_xfers", 32'(xfers), 1);

      // MSB-first unpack of two words, continuous requests.
      base = rd_pulses;
      fifo_data_in = W0;
      req(24'hAABBCC, 0); req(24'h112233, 0); req(24'h445566, 0); req(24'h778899, 1);
      fifo_data_in = W2;
      req(24'h555555, 0); req(24'h666666, 0); req(24'h777777, 0); req(24'h888888, 1);
      data_req = 1'b0;
      cycle();
      check("rd_pulses", 32'(rd_pulses - base), 2);
      check("hold_pixel", 32'(pixel_data), 32'h888888);

      // Line credits with burst_ready held low.
      burst_ready = 1'b0; frame_start = 1'b1;
      cycle();
      frame_start = 1'b0;
      cycle();
      base = xfers;
      for (int i = 0; i < 5; i++) begin
         line_start = 1'b1; cycle(); line_start = 1'b0; cycle();
      end
      check("line_cnt_sat", 32'(line_cnt), 4);
      check("credits_held", 32'(burst_valid), 1);
      burst_ready = 1'b1;
      for (int i = 0; i < 8; i++) cycle();
      check("line_xfers", 32'(xfers - base), 4);
      check("credits_drained", 32'(burst_valid), 0);
      check("no_underflow", 32'(underflow), 0);
      burst_ready = 1'b0;

      // Underflow mid-word.
      fifo_data_in = W1;
      req(24'h111111, 0); req(24'h222222, 0);
      fifo_empty = 1'b1;
      req(Fill, 0);
      check("underflow_set", 32'(underflow), 1);
      fifo_empty = 1'b0;
      req(24'h333333, 0); req(24'h444444, 1);
      data_req = 1'b0;
      cycle();
      check("underflow_sticky", 32'(underflow), 1);

      // Reset mid-frame with pending burst and slot 3.
      frame_start = 1'b1; cycle(); frame_start = 1'b0; cycle();
      line_start = 1'b1; cycle(); line_start = 1'b0;
      req(24'h111111, 0); req(24'h222222, 0); req(24'h333333, 0);
      fifo_empty = 1'b1; req(Fill, 0); fifo_empty = 1'b0;
      data_req = 1'b0;
      check("pre_rst_valid", 32'(burst_valid), 1);
      check("pre_rst_line", 32'(line_cnt), 1);
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      check("mid_rst_pixel", 32'(pixel_data), 0);
      check("mid_rst_valid", 32'(burst_valid), 0);
      check("mid_rst_underflow", 32'(underflow), 0);
      check("mid_rst_line", 32'(line_cnt), 0);
      check("mid_rst_fifo_rst_n", 32'(fifo_rst_n), 1);
      data_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1 check("post_rst_rd_en", 32'(fifo_rd_en), 0);
         cycle();
      end
      check("post_rst_pixel", 32'(pixel_data), 0);
      data_req = 1'b0;

      // Restart: slot counter from 0, then frame_start coincident with data_req.
      burst_ready = 1'b1; frame_start = 1'b1; cycle(); frame_start = 1'b0; cycle();
      req(24'h111111, 0); req(24'h222222, 0);
      frame_start = 1'b1;
      req(24'h333333, 0);
      frame_start = 1'b0;
      req(24'h111111, 0);
      data_req = 1'b0;
      cycle();
      check("final_valid", 32'(burst_valid), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
